pe_accum_requant: RTL and testbench

Downstream stage of the processing-element dot-product adder tree. Consumes each registered partial dot product (y + v_valid) and accumulates a configurable number of channel tiles into one output. Adds bias, round-shifts, optionally applies ReLU, saturates to the activation width, and queues results in a small output FIFO with a valid/ready handshake toward writeback.

---
 rtl/pe_accum_requant.sv | 261 ++++++++++++++++++++++++++
 tb/tb_pe_accum_requant.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_accum_requant.sv
// pe_accum_requant
// Accumulates cfg_tiles signed partial sums per output. It adds the bias,
// round-shifts, applies an optional ReLU and saturates to W_O bits. Each
// result then goes into a small show-ahead FIFO toward writeback.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   start            one-cycle pulse; latches cfg_* and bias when idle
//   cfg_tiles        partial sums per output (0 behaves as 1)
//   cfg_outputs      outputs per job (0 behaves as 1)
//   cfg_shift        arithmetic right shift with round-half-up
//   cfg_relu         clamp negative results to zero
//   bias             signed bias added to every output
//   y_in, y_valid    partial-sum stream (no upstream backpressure)
//   m_data, m_valid  FIFO head / FIFO non-empty
//   m_ready          consumer pops the FIFO head
//   busy             job in progress (ACCUM or DRAIN)
//   done             one-cycle pulse once the last result has left the pipeline
//   ovf              sticky: a result was dropped on a full FIFO
module pe_accum_requant #(
  parameter int W_Y        = 19,
  parameter int MAX_TILES  = 16,
  parameter int W_B        = 16,
  parameter int W_O        = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          start,
  input  logic [$clog2(MAX_TILES):0]    cfg_tiles,
  input  logic [15:0]                   cfg_outputs,
  input  logic [4:0]                    cfg_shift,
  input  logic                          cfg_relu,
  input  logic [W_B-1:0]                bias,
  input  logic [W_Y-1:0]                y_in,
  input  logic                          y_valid,
  output logic [W_O-1:0]                m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          ovf
);
  localparam int W_T   = $clog2(MAX_TILES) + 1;
  localparam int W_ACC = W_Y + $clog2(MAX_TILES);
  localparam int W_S1  = W_ACC + 2;
  localparam int W_P   = $clog2(FIFO_DEPTH);

  localparam logic [W_S1-1:0]        ONE_S1  = {{(W_S1-1){1'b0}}, 1'b1};
  localparam logic signed [W_S1-1:0] SAT_MAX = {{(W_S1-W_O+1){1'b0}}, {(W_O-1){1'b1}}};
  localparam logic signed [W_S1-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [W_T-1:0]          tiles_q, tiles_d, tile_cnt_q, tile_cnt_d;
  logic [15:0]             outputs_q, outputs_d, out_cnt_q, out_cnt_d;
  logic [4:0]              shift_q, shift_d;
  logic                    relu_q, relu_d;
  logic [W_B-1:0]          bias_q, bias_d;
  logic signed [W_ACC-1:0] acc_q, acc_d, sum_s;
  logic signed [W_S1-1:0]  s1_q, s1_d, round_s, s1_sum_s, shifted_s, clamp_s;
  logic                    s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [W_O-1:0]          s2_q, s2_d, sat_s;
  logic [W_O-1:0]          mem_q [FIFO_DEPTH];
  logic [W_O-1:0]          mem_d [FIFO_DEPTH];
  logic [W_P-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W_P:0]            cnt_q, cnt_d;
  logic                    busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic                    push_s, pop_s, full_s, drop_s;

  // Arithmetic: running sum, stage-1 biased/rounded value, stage-2 requantised value
  always_comb begin
    sum_s = acc_q + $signed({{(W_ACC-W_Y){y_in[W_Y-1]}}, y_in});
    if (shift_q != 5'd0) begin
      round_s = $signed(ONE_S1 << (shift_q - 5'd1));
    end else begin
      round_s = {W_S1{1'b0}};
    end
    s1_sum_s = $signed({{2{sum_s[W_ACC-1]}}, sum_s})
             + $signed({{(W_S1-W_B){bias_q[W_B-1]}}, bias_q})
             + round_s;
    shifted_s = s1_q >>> shift_q;
    if (relu_q && shifted_s[W_S1-1]) begin
      clamp_s = {W_S1{1'b0}};
    end else begin
      clamp_s = shifted_s;
    end
    if (clamp_s > SAT_MAX) begin
      sat_s = {1'b0, {(W_O-1){1'b1}}};
    end else if (clamp_s < SAT_MIN) begin
      sat_s = {1'b1, {(W_O-1){1'b0}}};
    end else begin
      sat_s = clamp_s[W_O-1:0];
    end
  end

  // Control FSM: config latch, tile/output counting, stage-1 load, drain and done
  always_comb begin
    state_d    = state_q;
    tiles_d    = tiles_q;
    outputs_d  = outputs_q;
    shift_d    = shift_q;
    relu_d     = relu_q;
    bias_d     = bias_q;
    acc_d      = acc_q;
    tile_cnt_d = tile_cnt_q;
    out_cnt_d  = out_cnt_q;
    s1_d       = s1_q;
    s1_v_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          tiles_d    = (cfg_tiles == {W_T{1'b0}}) ? W_T'(1) : cfg_tiles;
          outputs_d  = (cfg_outputs == 16'd0) ? 16'd1 : cfg_outputs;
          shift_d    = cfg_shift;
          relu_d     = cfg_relu;
          bias_d     = bias;
          acc_d      = {W_ACC{1'b0}};
          tile_cnt_d = {W_T{1'b0}};
          out_cnt_d  = 16'd0;
          state_d    = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (y_valid) begin
          if (tile_cnt_q < (tiles_q - W_T'(1))) begin
            acc_d      = sum_s;
            tile_cnt_d = tile_cnt_q + W_T'(1);
          end else begin
            // Final beat: hand the sum to stage 1 and restart the accumulator
            // in the same cycle so back-to-back final beats are never lost.
            s1_d       = s1_sum_s;
            s1_v_d     = 1'b1;
            acc_d      = {W_ACC{1'b0}};
            tile_cnt_d = {W_T{1'b0}};
            out_cnt_d  = out_cnt_q + 16'd1;
            if (out_cnt_q == (outputs_q - 16'd1)) begin
              state_d = DRAIN;
            end else begin
              state_d = ACCUM;
            end
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DRAIN: begin
        // The FIFO may still hold data; only the pipeline has to be empty.
        if (!s1_v_q && !s2_v_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Stage 2 and output FIFO: push requantised value, pop on handshake, flag drops
  always_comb begin
    s2_v_d = s1_v_q;
    if (s1_v_q) begin
      s2_d = sat_s;
    end else begin
      s2_d = s2_q;
    end
    pop_s  = (cnt_q != {(W_P+1){1'b0}}) && m_ready;
    full_s = (cnt_q == (W_P+1)'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_s = s2_v_q && (!full_s || pop_s);
    drop_s = s2_v_q && full_s && !pop_s;
    mem_d  = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = s2_q;
      wr_ptr_d        = wr_ptr_q + W_P'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + W_P'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + (W_P+1)'(1);
      2'b01:   cnt_d = cnt_q - (W_P+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if ((state_q == IDLE) && start) begin
      ovf_d = 1'b0;
    end else if (drop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      tiles_q    <= W_T'(1);
      outputs_q  <= 16'd1;
      shift_q    <= 5'd0;
      relu_q     <= 1'b0;
      bias_q     <= {W_B{1'b0}};
      acc_q      <= {W_ACC{1'b0}};
      tile_cnt_q <= {W_T{1'b0}};
      out_cnt_q  <= 16'd0;
      s1_q       <= {W_S1{1'b0}};
      s1_v_q     <= 1'b0;
      s2_q       <= {W_O{1'b0}};
      s2_v_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {W_O{1'b0}};
      end
      wr_ptr_q   <= {W_P{1'b0}};
      rd_ptr_q   <= {W_P{1'b0}};
      cnt_q      <= {(W_P+1){1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tiles_q    <= tiles_d;
      outputs_q  <= outputs_d;
      shift_q    <= shift_d;
      relu_q     <= relu_d;
      bias_q     <= bias_d;
      acc_q      <= acc_d;
      tile_cnt_q <= tile_cnt_d;
      out_cnt_q  <= out_cnt_d;
      s1_q       <= s1_d;
      s1_v_q     <= s1_v_d;
      s2_q       <= s2_d;
      s2_v_q     <= s2_v_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign m_data  = mem_q[rd_ptr_q];
  assign m_valid = (cnt_q != {(W_P+1){1'b0}});
  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_pe_accum_requant.sv
// Bench for pe_accum_requant: directed scenarios plus randomized jobs, all
// checked every cycle against a transaction-level model (integer arithmetic,
// a result queue with fixed latency, and a bounded FIFO queue).
module tb_pe_accum_requant;
  localparam int W_Y = 19, MAX_TILES = 16, W_B = 16, W_O = 8, FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic [4:0]        cfg_tiles = 5'd0;
  logic [15:0]       cfg_outputs = 16'd0;
  logic [4:0]        cfg_shift = 5'd0;
  logic              cfg_relu = 1'b0;
  logic [W_B-1:0]    bias = '0;
  logic [W_Y-1:0]    y_in = '0;
  logic              y_valid = 1'b0;
  logic [W_O-1:0]    m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              busy, done, ovf;

  always #5 clk = ~clk;

  pe_accum_requant #(.W_Y(W_Y), .MAX_TILES(MAX_TILES), .W_B(W_B), .W_O(W_O),
                     .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_tiles(cfg_tiles),
    .cfg_outputs(cfg_outputs), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .bias(bias), .y_in(y_in), .y_valid(y_valid), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done), .ovf(ovf)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  longint acc_m, bias_m, cyc, done_due;
  int     tile_m, out_m, tiles_m, outs_m, shift_m;
  bit     relu_m, busy_m, accum_m, ovf_m, done_m;
  int     fifo_m[$];
  longint pend_due[$];
  int     pend_val[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_result(input longint sum, input longint b,
                                      input int sh, input bit relu);
    longint s;
    longint r;
    s = sum + b + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : 0);
    r = s >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
    return int'(r);
  endfunction

  task automatic model_reset();
    acc_m = 0; tile_m = 0; out_m = 0; busy_m = 0; accum_m = 0;
    ovf_m = 0; done_m = 0; done_due = -1;
    fifo_m.delete(); pend_due.delete(); pend_val.delete();
  endtask

  // Advance the model over one clock edge, let the DUT take it, then compare.
  task automatic tick();
    bit was_busy, pop, push_ok, have_push;
    logic signed [W_Y-1:0] ys;
    logic signed [W_B-1:0] bs;
    logic signed [W_O-1:0] md;
    was_busy = busy_m;
    cyc++;
    pop = (fifo_m.size() > 0) && m_ready;
    have_push = (pend_due.size() > 0) && (pend_due[0] == cyc);
    push_ok = have_push && ((fifo_m.size() < FIFO_DEPTH) || pop);
    if (have_push && !push_ok) ovf_m = 1;
    if (pop) void'(fifo_m.pop_front());
    if (push_ok) fifo_m.push_back(pend_val[0]);
    if (have_push) begin
      void'(pend_due.pop_front());
      void'(pend_val.pop_front());
    end
    done_m = (cyc == done_due);
    if (done_m) busy_m = 0;
    if (!was_busy && start) begin
      tiles_m = (cfg_tiles == 0) ? 1 : int'(cfg_tiles);
      outs_m  = (cfg_outputs == 0) ? 1 : int'(cfg_outputs);
      shift_m = int'(cfg_shift);
      relu_m  = cfg_relu;
      bs = bias;
      bias_m = longint'(bs);
      busy_m = 1; accum_m = 1; ovf_m = 0;
      acc_m = 0; tile_m = 0; out_m = 0;
    end else if (accum_m && y_valid) begin
      ys = y_in;
      acc_m += longint'(ys);
      tile_m++;
      if (tile_m == tiles_m) begin
        pend_due.push_back(cyc + 2);
        pend_val.push_back(model_result(acc_m, bias_m, shift_m, relu_m));
        acc_m = 0; tile_m = 0; out_m++;
        if (out_m == outs_m) begin
          accum_m = 0;
          done_due = cyc + 3;
        end
      end
    end
    @(posedge clk);
    #1;
    check("m_valid", m_valid, fifo_m.size() > 0);
    if (fifo_m.size() > 0) begin
      md = m_data;
      check("m_data", longint'(md), fifo_m[0]);
    end
    check("busy", busy, busy_m);
    check("done", done, done_m);
    check("ovf", ovf, ovf_m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_job(input int t, input int o, input int b, input int s, input bit r);
    cfg_tiles = 5'(t); cfg_outputs = 16'(o); bias = W_B'(b);
    cfg_shift = 5'(s); cfg_relu = r;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input int y);
    y_valid = 1'b1;
    y_in = W_Y'(y);
    tick();
    y_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  // Asserts reset between edges and checks outputs clear immediately.
  task automatic do_reset();
    rstn = 1'b0;
    start = 1'b0; y_valid = 1'b0;
    #2;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [W_O-1:0] md;
    int n;
    cyc = 0;
    do_reset();
    idle(2);

    // Hand-computed values that pin the model
    check("pin_t1", model_result(300, -44, 2, 1'b0), 64);
    check("pin_sat_hi", model_result(5000, 0, 0, 1'b0), 127);
    check("pin_sat_lo", model_result(-1000, 0, 0, 1'b0), -128);
    check("pin_relu", model_result(-6, 0, 0, 1'b1), 0);
    check("pin_rnd_neg", model_result(-6, 0, 2, 1'b0), -1);
    check("pin_rnd_pos6", model_result(6, 0, 2, 1'b0), 2);
    check("pin_rnd_pos5", model_result(5, 0, 2, 1'b0), 1);

    // Two tiles, one output, with literal latency/done expectations
    m_ready = 1'b1;
    start_job(2, 1, -44, 2, 1'b0);
    beat(100);
    beat(200);
    tick();
    check("t1_early_valid", m_valid, 0);
    tick();
    md = m_data;
    check("t1_valid", m_valid, 1);
    check("t1_data", longint'(md), 64);
    tick();
    check("t1_done", done, 1);
    check("t1_busy", busy, 0);
    idle(2);

    // Saturation, without and with ReLU, back-to-back final beats
    start_job(1, 3, 0, 0, 1'b0);
    beat(5000); beat(-1000); beat(-6);
    wait_idle(20);
    start_job(1, 3, 0, 0, 1'b1);
    beat(5000); beat(-1000); beat(-6);
    wait_idle(20);

    // Rounding
    start_job(1, 3, 0, 2, 1'b0);
    beat(-6); beat(6); beat(5);
    wait_idle(20);
    idle(3);

    // Backpressure: fifth result dropped, ovf sticky until next start
    m_ready = 1'b0;
    start_job(1, 5, 0, 0, 1'b0);
    beat(10); beat(20); beat(30); beat(40); beat(50);
    wait_idle(20);
    check("bp_ovf", ovf, 1);
    m_ready = 1'b1;
    idle(6);
    check("bp_ovf_sticky", ovf, 1);
    check("bp_empty", m_valid, 0);

    // Push and pop together on a full FIFO
    m_ready = 1'b0;
    start_job(1, 5, 3, 0, 1'b0);
    check("pp_ovf_cleared", ovf, 0);
    beat(1); beat(2); beat(3); beat(4);
    idle(3);
    beat(5);
    tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("pp_ovf", ovf, 0);
    check("pp_valid", m_valid, 1);
    idle(3);
    m_ready = 1'b1;
    idle(6);

    // Start while busy is ignored
    start_job(2, 2, 10, 1, 1'b0);
    beat(7);
    cfg_tiles = 5'd1; cfg_outputs = 16'd9; cfg_shift = 5'd0; bias = 16'd500;
    start = 1'b1; y_valid = 1'b1; y_in = W_Y'(3);
    tick();
    start = 1'b0; y_valid = 1'b0;
    beat(11); beat(13);
    wait_idle(20);
    idle(3);

    // Reset mid-job with two entries queued
    m_ready = 1'b0;
    start_job(1, 6, 0, 0, 1'b0);
    beat(1); beat(2);
    idle(3);
    beat(9);
    do_reset();
    idle(2);

    // Randomized jobs
    for (int j = 0; j < 40; j++) begin
      m_ready = 1'($urandom_range(0, 1));
      start_job($urandom_range(0, 16), $urandom_range(0, 6), $urandom_range(0, 65535),
                $urandom_range(0, 12), 1'($urandom_range(0, 1)));
      n = 0;
      while (busy && n < 3000) begin
        y_valid = ($urandom_range(0, 9) < 7);
        y_in = W_Y'($urandom);
        m_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) begin
          start = 1'b1;
          cfg_tiles = 5'($urandom_range(0, 16));
          cfg_outputs = 16'($urandom_range(0, 6));
          cfg_shift = 5'($urandom_range(0, 12));
          bias = W_B'($urandom);
        end
        tick();
        start = 1'b0;
        n++;
      end
      y_valid = 1'b0;
      if (busy) begin
        checks++;
        errors++;
        $display("FAIL rand_job_timeout: busy still 1 after %0d cycles, expected 0", n);
      end
      idle($urandom_range(0, 3));
    end

    m_ready = 1'b1;
    idle(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
